// File: rtl/eda_pkg.sv
// Shared types and helpers for the regional-max image scan sequencer.
package eda_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} eda_scan_state_e;

    // Neighbour-valid bit positions in the 3x3 window
    localparam int unsigned NB_UL = 7;
    localparam int unsigned NB_U  = 6;
    localparam int unsigned NB_UR = 5;
    localparam int unsigned NB_L  = 4;
    localparam int unsigned NB_R  = 3;
    localparam int unsigned NB_DL = 2;
    localparam int unsigned NB_D  = 1;
    localparam int unsigned NB_DR = 0;

    // Window lane holding neighbour bit nb_bit; the centre lane sits between l and r
    function automatic int unsigned win_lane(input int unsigned nb_bit, input int unsigned center_lane);
        return (nb_bit >= center_lane) ? nb_bit + 1 : nb_bit;
    endfunction

    // LSB position of a lane inside the packed window vector
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/eda_window_cmp.sv
// Combinational regional-max test: centre >= every valid neighbour (unsigned, ties pass).
module eda_window_cmp
    import eda_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WINDOW_WIDTH = 9
) (
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
    output logic                                is_max_c
);

    localparam int unsigned NB_CNT      = WINDOW_WIDTH - 1;
    localparam int unsigned CENTER_LANE = NB_CNT / 2;

    logic [PIXEL_WIDTH-1:0] center_pix;

    always_comb begin
        center_pix = window_values[lane_lsb(CENTER_LANE, PIXEL_WIDTH) +: PIXEL_WIDTH];
        is_max_c   = 1'b1;
        for (int unsigned k = 0; k < NB_CNT; k++) begin
            if (neigh_addr_valid[k] &&
                (window_values[lane_lsb(win_lane(k, CENTER_LANE), PIXEL_WIDTH) +: PIXEL_WIDTH] > center_pix)) begin
                is_max_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/eda_img_scan_ctrl.sv
// Image RAM sequencer: raster LOAD, then SCAN of every pixel emitting {addr, is_max} results.
// Optional macro EDA_SCAN_STALL_CNT_EN adds the stall_cnt output (result backpressure cycles).
module eda_img_scan_ctrl
    import eda_pkg::*;
#(
    parameter int unsigned M            = 16,
    parameter int unsigned N            = 16,
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WINDOW_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH   = $clog2(M*N)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    input  logic [PIXEL_WIDTH-1:0]              pix_data,
    output logic                                write_en,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [PIXEL_WIDTH-1:0]              pixel_in,
    output logic [ADDR_WIDTH-1:0]               center_addr,
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ADDR_WIDTH-1:0]               res_addr,
    output logic                                res_is_max,
    output logic                                busy,
`ifdef EDA_SCAN_STALL_CNT_EN
    output logic [31:0]                         stall_cnt,
`endif
    output logic                                done
);

    localparam int unsigned PIX_TOTAL = M * N;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_TOTAL - 1);

    eda_scan_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] load_cnt;
    logic [ADDR_WIDTH-1:0] scan_cnt;
    logic                  scan_last;
    logic                  is_max_c;
    logic                  res_load_c;
    logic                  res_last_fire_c;

    eda_window_cmp #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .WINDOW_WIDTH(WINDOW_WIDTH)
    ) u_window_cmp (
        .window_values   (window_values),
        .neigh_addr_valid(neigh_addr_valid),
        .is_max_c        (is_max_c)
    );

    // Result slot refills when empty or draining; scan_last stops new centres after the final pixel
    assign res_load_c      = (state == SCAN) && !scan_last && (!res_valid || res_ready);
    assign res_last_fire_c = (state == SCAN) && scan_last && res_valid && res_ready;
    assign center_addr     = scan_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        write_en  = 1'b0;
        wr_addr   = '0;
        pixel_in  = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (pix_valid) begin
                    write_en = 1'b1;
                    wr_addr  = load_cnt;
                    pixel_in = pix_data;
                    if (load_cnt == LAST_ADDR) state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (res_last_fire_c) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster write address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_cnt <= '0;
        end else if ((state == LOAD) && pix_valid) begin
            load_cnt <= (load_cnt == LAST_ADDR) ? '0 : load_cnt + ADDR_WIDTH'(1);
        end
    end

    // Window centre; holds at the last pixel rather than wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            scan_last <= 1'b0;
        end else if (res_last_fire_c) begin
            scan_cnt  <= '0;
            scan_last <= 1'b0;
        end else if (res_load_c) begin
            if (scan_cnt == LAST_ADDR) begin
                scan_last <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Single-entry result register on the valid/ready output stream
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_valid  <= 1'b0;
            res_addr   <= '0;
            res_is_max <= 1'b0;
        end else if (res_load_c) begin
            res_valid  <= 1'b1;
            res_addr   <= scan_cnt;
            res_is_max <= is_max_c;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef EDA_SCAN_STALL_CNT_EN
    // Backpressure cycles during SCAN, per frame, saturating
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == SCAN) && res_valid && !res_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eda_img_scan_ctrl.sv
// Bench for eda_img_scan_ctrl on a 4x4 image with an attached behavioural image RAM.
module tb_eda_img_scan_ctrl;
    import eda_pkg::*;

    localparam int PW = 8;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        write_en;
    logic [3:0]  wr_addr;
    logic [7:0]  pixel_in;
    logic [3:0]  center_addr;
    logic [71:0] window_values;
    logic [7:0]  neigh_addr_valid;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_addr;
    logic        res_is_max;
    logic        busy;
    logic        done;
`ifdef EDA_SCAN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    eda_img_scan_ctrl #(
        .M(4), .N(4), .PIXEL_WIDTH(8), .WINDOW_WIDTH(9)
    ) dut (
`ifdef EDA_SCAN_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .write_en        (write_en),
        .wr_addr         (wr_addr),
        .pixel_in        (pixel_in),
        .center_addr     (center_addr),
        .window_values   (window_values),
        .neigh_addr_valid(neigh_addr_valid),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_addr        (res_addr),
        .res_is_max      (res_is_max),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural image RAM with a 3x3 window read port; off-image lanes carry 8'hFF
    logic [7:0] ram [16];
    localparam int NB_MAP [9] = '{NB_UL, NB_U, NB_UR, NB_L, -1, NB_R, NB_DL, NB_D, NB_DR};
    int wc_p, wc_ni, wc_nj;

    always @(posedge clk) begin
        if (write_en) ram[wr_addr] <= pixel_in;
    end

    always_comb begin
        window_values    = '1;
        neigh_addr_valid = '0;
        wc_p  = 0;
        wc_ni = 0;
        wc_nj = 0;
        for (int di = -1; di <= 1; di++) begin
            for (int dj = -1; dj <= 1; dj++) begin
                wc_p  = (di + 1) * 3 + (dj + 1);
                wc_ni = int'(center_addr) / 4 + di;
                wc_nj = int'(center_addr) % 4 + dj;
                if (wc_ni >= 0 && wc_ni < 4 && wc_nj >= 0 && wc_nj < 4) begin
                    window_values[(8 - wc_p) * PW +: PW] = ram[wc_ni * 4 + wc_nj];
                    if (wc_p != 4) neigh_addr_valid[NB_MAP[wc_p]] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Regional-max reference: a pixel is max unless some in-image neighbour is strictly larger
    function automatic logic [15:0] model_max(input logic [127:0] img);
        logic [15:0] m;
        int r, c;
        m = '1;
        for (int a = 0; a < 16; a++) begin
            for (int di = -1; di <= 1; di++) begin
                for (int dj = -1; dj <= 1; dj++) begin
                    r = a / 4 + di;
                    c = a % 4 + dj;
                    if ((di != 0 || dj != 0) && r >= 0 && r < 4 && c >= 0 && c < 4) begin
                        if (img[(r * 4 + c) * 8 +: 8] > img[a * 8 +: 8]) m[a] = 1'b0;
                    end
                end
            end
        end
        return m;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_pix_ready"},   32'(pix_ready),   32'd0);
        check({tag, "_write_en"},    32'(write_en),    32'd0);
        check({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
        check({tag, "_pixel_in"},    32'(pixel_in),    32'd0);
        check({tag, "_center_addr"}, 32'(center_addr), 32'd0);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_res_addr"},    32'(res_addr),    32'd0);
        check({tag, "_res_is_max"},  32'(res_is_max),  32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
`ifdef EDA_SCAN_STALL_CNT_EN
        check({tag, "_stall_cnt"},   stall_cnt,        32'd0);
`endif
    endtask

    // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready plus random start pulses
    // vmode: 0 pix_valid held high, 1 random pix_valid gaps
    task automatic run_frame(input logic [127:0] img, input int rmode, input int vmode,
                             input logic [15:0] exp_max);
        int n, cyc, exp_idx, stalls, first_acc, last_acc, issued;
        bit finished, rdy;
        @(negedge clk);
        start = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pix_ready", 32'(pix_ready), 32'd0);
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 400) begin
            @(negedge clk);
            start     = 1'b0;
            pix_valid = (vmode == 0) ? 1'b1 : ($urandom % 4 != 0);
            pix_data  = img[n * 8 +: 8];
            #1;
            if (cyc == 0) check("busy_after_start", 32'(busy), 32'd1);
            check("load_pix_ready", 32'(pix_ready), 32'd1);
            check("load_write_en", 32'(write_en), 32'(pix_valid));
            check("load_done", 32'(done), 32'd0);
            if (pix_valid) begin
                check("wr_addr", 32'(wr_addr), 32'(n));
                check("pixel_in", 32'(pixel_in), 32'(img[n * 8 +: 8]));
                n++;
            end
            cyc++;
        end
        check("load_complete", 32'(n), 32'd16);

        exp_idx = 0; stalls = 0; first_acc = -1; last_acc = -1;
        finished = 1'b0; cyc = 0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom % 2);
            endcase
            res_ready = rdy;
            pix_valid = 1'($urandom % 2);
            pix_data  = 8'($urandom);
            start     = (rmode == 2) ? 1'($urandom % 2) : 1'b0;
            #1;
            if (done) begin
                finished = 1'b1;
                check("done_busy", 32'(busy), 32'd0);
                check("done_res_valid", 32'(res_valid), 32'd0);
            end else begin
                check("scan_write_en", 32'(write_en), 32'd0);
                check("scan_pix_ready", 32'(pix_ready), 32'd0);
                check("scan_busy", 32'(busy), 32'd1);
                issued = exp_idx + int'(res_valid);
                if (issued > 15) issued = 15;
                check("center_addr", 32'(center_addr), 32'(issued));
                if (res_valid) begin
                    if (exp_idx < 16) begin
                        check("res_addr", 32'(res_addr), 32'(exp_idx));
                        check("res_is_max", 32'(res_is_max), 32'(exp_max[exp_idx]));
                    end else begin
                        check("extra_result", 32'(exp_idx), 32'd15);
                    end
                    if (rdy) begin
                        if (first_acc < 0) first_acc = cyc;
                        last_acc = cyc;
                        exp_idx++;
                    end else begin
                        stalls++;
                    end
                end
            end
            cyc++;
        end
        check("done_seen", 32'(finished), 32'd1);
        check("result_count", 32'(exp_idx), 32'd16);
        if (rmode == 0) begin
            check("first_latency", 32'(first_acc), 32'd1);
            check("burst_len", 32'(last_acc - first_acc + 1), 32'd16);
        end
`ifdef EDA_SCAN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'(stalls));
`endif
        @(negedge clk);
        start     = 1'b0;
        res_ready = 1'b0;
        pix_valid = 1'b0;
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [127:0] img;
        int           rmode;
        int           vmode;
        logic [15:0]  exp_max;
    } frame_t;

    frame_t       tbl [4];
    logic [127:0] ramp, flat, peak, rnd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;

        for (int a = 0; a < 16; a++) begin
            ramp[a * 8 +: 8] = 8'(a);
            flat[a * 8 +: 8] = 8'h55;
            peak[a * 8 +: 8] = (a == 5) ? 8'hFF : 8'h10;
        end
        tbl[0] = '{img: ramp, rmode: 0, vmode: 0, exp_max: 16'h8000};
        tbl[1] = '{img: flat, rmode: 0, vmode: 0, exp_max: 16'hFFFF};
        tbl[2] = '{img: peak, rmode: 0, vmode: 0, exp_max: 16'hF8A8};
        tbl[3] = '{img: ramp, rmode: 1, vmode: 0, exp_max: 16'h8000};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_zero("rst");

        for (int t = 0; t < 4; t++) begin
            run_frame(tbl[t].img, tbl[t].rmode, tbl[t].vmode, tbl[t].exp_max);
        end

        // Abort a frame after seven pixels, then reload from scratch
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start     = 1'b0;
            pix_valid = 1'b1;
            pix_data  = 8'(k + 100);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_zero("midrst");
        repeat (3) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        run_frame(ramp, 2, 1, tbl[0].exp_max);

        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < 16; a++) begin
                rnd[a * 8 +: 8] = (f % 2 == 0) ? 8'(($urandom % 3) * 40) : 8'($urandom);
            end
            run_frame(rnd, f % 3, f % 2, model_max(rnd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
